// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding
// and the default fetch-starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of D grants that overtook a waiting fetch; cleared when
// fetch is finally granted.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [STARVE_W-1:0] o_cnt,
  output logic                o_at_limit
);

  logic [STARVE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != STARVE_W'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (read-only) and
// the memory stage (read/write); D-side wins unless fetch has been starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [AW-1:0]       i_addr,
  output logic [DW-1:0]       i_rdata,
  output logic                i_done,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [AW-1:0]       d_addr,
  input  logic [DW-1:0]       d_wdata,
  output logic [DW-1:0]       d_rdata,
  output logic                d_done,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_ack,
  input  logic [DW-1:0]       mem_rdata,
  output logic [1:0]          o_dbg_state,
  output logic [STARVE_W-1:0] o_dbg_starve_cnt
);

  // Handshake: a requester holds req and its operands stable until it sees its
  // one-cycle done pulse; memory side holds mem_req/mem_* until mem_ack, which
  // may arrive in the first mem_req cycle and carries mem_rdata.

  arb_state_t          r_state, w_state_nxt;
  logic                r_mem_req, r_mem_we;
  logic [AW-1:0]       r_mem_addr;
  logic [DW-1:0]       r_mem_wdata, r_i_rdata, r_d_rdata;
  logic                r_i_done, r_d_done;
  logic                w_i_elig, w_d_elig;
  logic                w_grant_i, w_grant_d, w_ack_i, w_ack_d;
  logic                w_at_limit;
  logic [STARVE_W-1:0] w_starve_cnt;

  // The done pulse masks the finishing requester so it cannot re-win the port
  // in the same cycle; the other side gets the grant instead.
  assign w_i_elig = i_req & ~r_i_done;
  assign w_d_elig = d_req & ~r_d_done;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_ack_i     = 1'b0;
    w_ack_d     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_elig && (!w_d_elig || w_at_limit)) begin
          w_grant_i   = 1'b1;
          w_state_nxt = GNT_I;
        end else if (w_d_elig) begin
          w_grant_d   = 1'b1;
          w_state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          w_ack_i     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          w_ack_d     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i_done <= w_ack_i;
      r_d_done <= w_ack_d;
      if (w_grant_i) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= i_addr;
      end else if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_ack_i || w_ack_d) begin
        r_mem_req <= 1'b0;
      end
      if (w_ack_i) begin
        r_i_rdata <= mem_rdata;
      end
      // Writes leave the last D read result visible.
      if (w_ack_d && !r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  arb_starve_ctr #(
    .LIMIT(STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_grant_d & w_i_elig),
    .i_clr     (w_grant_i),
    .o_cnt     (w_starve_cnt),
    .o_at_limit(w_at_limit)
  );

  assign i_rdata          = r_i_rdata;
  assign i_done           = r_i_done;
  assign i_stall          = i_req & ~r_i_done;
  assign d_rdata          = r_d_rdata;
  assign d_done           = r_d_done;
  assign d_stall          = d_req & ~r_d_done;
  assign mem_req          = r_mem_req;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = w_starve_cnt;

endmodule
